// File: rtl/dmx_input_receiver.sv
// DMX512 receiver: synchronises the RS-485 line, decodes BREAK/MAB/start code/slots
// and streams each slot into a dual-port EBR through a write-only port.
module dmx_input_receiver #(
  parameter int unsigned CLK_FREQ     = 20_000_000,
  parameter int unsigned BAUD_RATE    = 250_000,
  parameter int unsigned BREAK_MIN_US = 88,
  parameter int unsigned MAB_MIN_US   = 8,
  parameter int unsigned MAX_CHANNELS = 512,
  parameter int unsigned LOSS_TIMEOUT = CLK_FREQ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       DMX_In,
  input  logic       Enable,
  output logic [9:0] EBR_Addr_Wr,
  output logic [7:0] EBR_Data_Wr,
  output logic       EBR_Wr,
  output logic       Frame_Done,
  output logic [9:0] Rx_Channel_Count,
  output logic [7:0] Start_Code,
  output logic       Framing_Error,
  output logic       Signal_Present
);

  localparam int unsigned BIT_CLKS   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BREAK_CLKS = CLK_FREQ / 1_000_000 * BREAK_MIN_US;
  localparam int unsigned MAB_CLKS   = CLK_FREQ / 1_000_000 * MAB_MIN_US;

  localparam logic [15:0] BIT_LAST  = 16'(BIT_CLKS - 1);
  localparam logic [15:0] HALF_LAST = 16'(BIT_CLKS / 2 - 1);
  localparam logic [15:0] MAB_MIN   = 16'(MAB_CLKS);
  localparam logic [15:0] BRK_MIN   = 16'(BREAK_CLKS);
  localparam logic [9:0]  MAX_SLOTS = 10'(MAX_CHANNELS);
  localparam logic [31:0] LOSS_LOAD = 32'(LOSS_TIMEOUT);

  typedef enum logic [2:0] {
    WAIT_BREAK, BREAK, MAB, START, DATA, STOP, IDLE_SLOT
  } state_t;

  state_t      state, state_n;
  logic        sync1, rx_s, rx_d;
  logic [15:0] low_cnt;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shreg, sh_n;
  logic [9:0]  slot_idx, idx_n;
  logic [9:0]  slot_cnt, scnt_n;
  logic        done, done_n;
  logic [31:0] loss_tmr;
  logic [9:0]  addr_n, rcc_n;
  logic [7:0]  data_n, sc_n;
  logic        wr_n, fd_n, fe_n;
  logic        fall, force_brk;

  // Line idles high, so the synchroniser resets to mark to avoid a phantom low run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      low_cnt <= '0;
    end else begin
      sync1 <= DMX_In;
      rx_s  <= sync1;
      rx_d  <= rx_s;
      if (rx_s)                 low_cnt <= '0;
      else if (low_cnt != BRK_MIN) low_cnt <= low_cnt + 16'd1;
    end
  end

  assign fall      = rx_d & ~rx_s;
  assign force_brk = (low_cnt == BRK_MIN) && (state != BREAK);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    idx_n   = slot_idx;
    scnt_n  = slot_cnt;
    done_n  = done;
    addr_n  = EBR_Addr_Wr;
    data_n  = EBR_Data_Wr;
    rcc_n   = Rx_Channel_Count;
    sc_n    = Start_Code;
    wr_n    = 1'b0;
    fd_n    = 1'b0;
    fe_n    = 1'b0;
    if (!Enable) begin
      state_n = WAIT_BREAK;
      cnt_n   = '0;
      idx_n   = '0;
      scnt_n  = '0;
      done_n  = 1'b0;
    end else if (force_brk) begin
      // A full BREAK closes whatever frame was in flight.
      if (slot_cnt != 10'd0 && !done) begin
        fd_n  = 1'b1;
        rcc_n = slot_cnt;
      end
      state_n = BREAK;
      cnt_n   = '0;
      idx_n   = '0;
      scnt_n  = '0;
      done_n  = 1'b0;
    end else begin
      if (EBR_Wr && slot_cnt == MAX_SLOTS && !done) begin
        fd_n   = 1'b1;
        rcc_n  = slot_cnt;
        done_n = 1'b1;
      end
      case (state)
        WAIT_BREAK: ;
        BREAK: if (rx_s) begin
          state_n = MAB;
          cnt_n   = '0;
        end
        MAB: begin
          if (!rx_s) begin
            if (cnt < MAB_MIN) state_n = WAIT_BREAK;
            else begin
              state_n = START;
              cnt_n   = '0;
              idx_n   = '0;
            end
          end else if (cnt < MAB_MIN) cnt_n = cnt + 16'd1;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_n = '0;
            if (!rx_s) begin
              state_n = DATA;
              bit_n   = '0;
            end else state_n = IDLE_SLOT;
          end else cnt_n = cnt + 16'd1;
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt_n = '0;
            sh_n  = {rx_s, shreg[7:1]};
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = STOP;
          end else cnt_n = cnt + 16'd1;
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt_n   = '0;
            state_n = WAIT_BREAK;
            if (rx_s) begin
              if (slot_idx == 10'd0) begin
                sc_n = shreg;
                if (shreg == 8'h00) begin
                  idx_n   = 10'd1;
                  state_n = IDLE_SLOT;
                end
              end else begin
                addr_n = slot_idx - 10'd1;
                data_n = shreg;
                wr_n   = 1'b1;
                scnt_n = slot_idx;
                if (slot_idx != MAX_SLOTS) begin
                  idx_n   = slot_idx + 10'd1;
                  state_n = IDLE_SLOT;
                end
              end
            end else if (shreg != 8'h00) begin
              // Corrupted frame: keep what was written but never report it complete.
              fe_n   = 1'b1;
              scnt_n = '0;
            end
          end else cnt_n = cnt + 16'd1;
        end
        IDLE_SLOT: if (fall) begin
          state_n = START;
          cnt_n   = '0;
        end
        default: state_n = WAIT_BREAK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= WAIT_BREAK;
      cnt              <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      slot_idx         <= '0;
      slot_cnt         <= '0;
      done             <= 1'b0;
      EBR_Addr_Wr      <= '0;
      EBR_Data_Wr      <= '0;
      EBR_Wr           <= 1'b0;
      Frame_Done       <= 1'b0;
      Rx_Channel_Count <= '0;
      Start_Code       <= '0;
      Framing_Error    <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      bit_cnt          <= bit_n;
      shreg            <= sh_n;
      slot_idx         <= idx_n;
      slot_cnt         <= scnt_n;
      done             <= done_n;
      EBR_Addr_Wr      <= addr_n;
      EBR_Data_Wr      <= data_n;
      EBR_Wr           <= wr_n;
      Frame_Done       <= fd_n;
      Rx_Channel_Count <= rcc_n;
      Start_Code       <= sc_n;
      Framing_Error    <= fe_n;
    end
  end

  // Signal_Present drops exactly LOSS_TIMEOUT cycles after the last Frame_Done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_tmr       <= '0;
      Signal_Present <= 1'b0;
    end else if (!Enable) begin
      loss_tmr       <= '0;
      Signal_Present <= 1'b0;
    end else if (fd_n) begin
      loss_tmr       <= LOSS_LOAD;
      Signal_Present <= 1'b1;
    end else if (loss_tmr != 32'd0) begin
      loss_tmr <= loss_tmr - 32'd1;
      if (loss_tmr == 32'd1) Signal_Present <= 1'b0;
    end
  end

endmodule
